// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: ALU opcode and condition encodings, NZCV bit indices, sequencer states, opcode classifiers
package alu_seq_pkg;
  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;
  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;
  localparam int FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  function automatic logic is_test_op(input logic [3:0] op);
    return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
  endfunction
  function automatic logic is_logical_op(input logic [3:0] op);
    return op inside {OP_AND, OP_EOR, OP_TST, OP_TEQ, OP_ORR, OP_MOV, OP_BIC, OP_MVN};
  endfunction
endpackage

// File: rtl/alu_cond_eval.sv
// alu_cond_eval: evaluates an ARM condition code against NZCV
module alu_cond_eval
  import alu_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;
  logic [7:0] base;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];
  assign base = {1'b1, !z && (n == v), n == v, c && !z, v, n, c, z};
  assign pass = base[cond[3:1]] ^ cond[0];
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sequences one op per request through the external ALU; ALU_SEQ_PERF_CNT_EN adds perf_exec/perf_skip counters
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W = 4
`ifdef ALU_SEQ_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [3:0]        req_cond,
  input  logic              req_s,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [RD_W-1:0]   req_rd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_wb_en,
  output logic [RD_W-1:0]   res_rd,
  output logic [DATA_W-1:0] res_data,
  output logic [3:0]        flags
`ifdef ALU_SEQ_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_exec
  , output logic [CNT_W-1:0] perf_skip
`endif
);
  state_t state, state_nx;
  logic [3:0] h_cond;
  logic h_s;
  logic [RD_W-1:0] h_rd;
  logic pass, upd;
  logic [3:0] flags_nx;
  alu_cond_eval u_cond (.cond(h_cond), .flags(flags), .pass(pass));
  assign alu_cin = flags[FLAG_C];
  assign upd = pass && (h_s || is_test_op(alu_op));
  assign flags_nx = is_logical_op(alu_op) ? {alu_n, alu_z, flags[FLAG_C], flags[FLAG_V]}
                                          : {alu_n, alu_z, alu_c, alu_v};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    req_ready = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        state_nx = req_valid ? EXEC : IDLE;
      end
      EXEC: state_nx = RESP;
      RESP: begin
        res_valid = 1'b1;
        state_nx = res_ready ? IDLE : RESP;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      h_cond <= '0;
      h_s <= 1'b0;
      h_rd <= '0;
      res_wb_en <= 1'b0;
      res_rd <= '0;
      res_data <= '0;
      flags <= '0;
    end else if (state == IDLE && req_valid) begin
      alu_a <= req_a;
      alu_b <= req_b;
      alu_op <= req_op;
      h_cond <= req_cond;
      h_s <= req_s;
      h_rd <= req_rd;
    end else if (state == EXEC) begin
      res_wb_en <= pass && !is_test_op(alu_op);
      res_rd <= h_rd;
      res_data <= alu_result;
      flags <= upd ? flags_nx : flags;
    end
`ifdef ALU_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_exec <= '0;
      perf_skip <= '0;
    end else if (state == EXEC) begin
      perf_exec <= pass && !(&perf_exec) ? perf_exec + 1'b1 : perf_exec;
      perf_skip <= !pass && !(&perf_skip) ? perf_skip + 1'b1 : perf_skip;
    end
`endif
endmodule
